// File: rtl/ysyx_23060332_mem_arb_pkg.sv
// Shared widths, constants and FSM encodings for the IFU/LSU memory arbiter.
package ysyx_23060332_mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } arb_owner_e;

endpackage

// File: rtl/ysyx_23060332_mem_arb.sv
// Round-robin arbiter serialising IFU fetches and LSU loads/stores onto a single
// memory port, one transaction outstanding at a time.
module ysyx_23060332_mem_arb
    import ysyx_23060332_mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [DATA_W-1:0] ifu_rdata,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_rsp_valid,
    input  logic              lsu_rsp_ready,
    output logic [DATA_W-1:0] lsu_rdata,

    output logic              mem_valid,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] WAIT_CYCLES = CNT_W'(LATENCY - 1);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    arb_owner_e        last_q,  last_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              wen_q,   wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [DATA_W-1:0] rsp_q,   rsp_d;

    logic grant_ifu;
    logic grant_lsu;
    logic accept;
    logic in_access;
    logic in_resp;
    logic owner_ready;

    // On a tie the requester that did not win last time gets the slot.
    assign grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_q == OWN_LSU));
    assign grant_lsu = lsu_req_valid && !grant_ifu;

    // Every output is masked by rst so an in-flight store can never reach memory.
    assign ifu_req_ready = !rst && (state_q == ST_IDLE) && grant_ifu;
    assign lsu_req_ready = !rst && (state_q == ST_IDLE) && grant_lsu;
    assign accept        = ifu_req_ready || lsu_req_ready;

    assign in_access = !rst && (state_q == ST_ACCESS);
    assign in_resp   = !rst && (state_q == ST_RESP);

    assign mem_valid = in_access;
    assign mem_ren   = in_access && !wen_q;
    assign mem_wen   = in_access && wen_q;
    assign mem_raddr = in_access ? addr_q  : '0;
    assign mem_waddr = in_access ? addr_q  : '0;
    assign mem_wdata = in_access ? wdata_q : '0;
    assign mem_wmask = in_access ? wmask_q : '0;

    assign ifu_rsp_valid = in_resp && (owner_q == OWN_IFU);
    assign lsu_rsp_valid = in_resp && (owner_q == OWN_LSU);
    assign ifu_rdata     = ifu_rsp_valid ? rsp_q : ZERO_WORD;
    assign lsu_rdata     = lsu_rsp_valid ? rsp_q : ZERO_WORD;

    assign owner_ready = (owner_q == OWN_IFU) ? ifu_rsp_ready : lsu_rsp_ready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rsp_d   = rsp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = grant_ifu ? OWN_IFU : OWN_LSU;
                    last_d  = grant_ifu ? OWN_IFU : OWN_LSU;
                    addr_d  = grant_ifu ? ifu_addr : lsu_addr;
                    wen_d   = grant_lsu && lsu_wen;
                    wdata_d = grant_lsu ? lsu_wdata : ZERO_WORD;
                    wmask_d = grant_lsu ? lsu_wmask : '0;
                    cnt_d   = WAIT_CYCLES;
                    state_d = (WAIT_CYCLES == '0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                rsp_d   = wen_q ? ZERO_WORD : mem_rdata;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (owner_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_LSU;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rsp_q   <= rsp_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_mem_arb.sv
// Directed bench: one arbiter at LATENCY=1 and one at LATENCY=3, selected by sel.
module tb_ysyx_23060332_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_rsp_ready;
    logic        lsu_req_valid, lsu_wen, lsu_rsp_ready;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
    logic [7:0]  lsu_wmask;
    int          sel;

    logic        v_ifu [2];
    logic        v_lsu [2];
    logic        o_ifu_req_ready [2];
    logic        o_ifu_rsp_valid [2];
    logic [31:0] o_ifu_rdata     [2];
    logic        o_lsu_req_ready [2];
    logic        o_lsu_rsp_valid [2];
    logic [31:0] o_lsu_rdata     [2];
    logic        o_mem_valid     [2];
    logic        o_mem_ren       [2];
    logic        o_mem_wen       [2];
    logic [31:0] o_mem_raddr     [2];
    logic [31:0] o_mem_waddr     [2];
    logic [31:0] o_mem_wdata     [2];
    logic [7:0]  o_mem_wmask     [2];

    int chk  = 0;
    int pass = 0;

    assign v_ifu[0] = ifu_req_valid && (sel == 0);
    assign v_ifu[1] = ifu_req_valid && (sel == 1);
    assign v_lsu[0] = lsu_req_valid && (sel == 0);
    assign v_lsu[1] = lsu_req_valid && (sel == 1);

    always #5 clk = ~clk;

    ysyx_23060332_mem_arb #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(v_ifu[0]), .ifu_req_ready(o_ifu_req_ready[0]), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(o_ifu_rsp_valid[0]), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(o_ifu_rdata[0]),
        .lsu_req_valid(v_lsu[0]), .lsu_req_ready(o_lsu_req_ready[0]), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(o_lsu_rsp_valid[0]), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(o_lsu_rdata[0]),
        .mem_valid(o_mem_valid[0]), .mem_ren(o_mem_ren[0]), .mem_wen(o_mem_wen[0]),
        .mem_raddr(o_mem_raddr[0]), .mem_waddr(o_mem_waddr[0]), .mem_wdata(o_mem_wdata[0]),
        .mem_wmask(o_mem_wmask[0]), .mem_rdata(mem_rdata)
    );

    ysyx_23060332_mem_arb #(.LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(v_ifu[1]), .ifu_req_ready(o_ifu_req_ready[1]), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(o_ifu_rsp_valid[1]), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(o_ifu_rdata[1]),
        .lsu_req_valid(v_lsu[1]), .lsu_req_ready(o_lsu_req_ready[1]), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(o_lsu_rsp_valid[1]), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(o_lsu_rdata[1]),
        .mem_valid(o_mem_valid[1]), .mem_ren(o_mem_ren[1]), .mem_wen(o_mem_wen[1]),
        .mem_raddr(o_mem_raddr[1]), .mem_waddr(o_mem_waddr[1]), .mem_wdata(o_mem_wdata[1]),
        .mem_wmask(o_mem_wmask[1]), .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ifu_req_valid = 1'b0; ifu_rsp_ready = 1'b0; ifu_addr  = '0;
        lsu_req_valid = 1'b0; lsu_rsp_ready = 1'b0; lsu_wen   = 1'b0;
        lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; mem_rdata = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] agg;
        sel = 0;
        do_reset();
        rst = 1'b1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk++;
        if ({o_ifu_req_ready[0], o_lsu_req_ready[0]} !== 2'b00)
            $display("FAIL reset_ready: got %b want 00", {o_ifu_req_ready[0], o_lsu_req_ready[0]});
        else pass++;
        agg = o_ifu_rdata[0] | o_lsu_rdata[0] | o_mem_raddr[0] | o_mem_waddr[0] | o_mem_wdata[0]
              | {24'd0, o_mem_wmask[0]}
              | {27'd0, o_ifu_rsp_valid[0], o_lsu_rsp_valid[0], o_mem_valid[0], o_mem_ren[0], o_mem_wen[0]};
        chk++;
        if (agg !== 32'd0) $display("FAIL reset_outputs: got %h want 00000000", agg);
        else pass++;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk++;
        if ({o_ifu_req_ready[0], o_lsu_req_ready[0]} !== 2'b10)
            $display("FAIL reset_first_tie: got %b want 10", {o_ifu_req_ready[0], o_lsu_req_ready[0]});
        else pass++;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    endtask

    task automatic test_ifu_read();
        sel = 0;
        do_reset();
        ifu_addr = 32'h8000_0000; ifu_req_valid = 1'b1; ifu_rsp_ready = 1'b1;
        mem_rdata = 32'h0000_0413;
        @(negedge clk);
        chk++;
        if ({o_ifu_req_ready[0], o_lsu_req_ready[0], o_mem_valid[0]} !== 3'b100)
            $display("FAIL ifu_t0: got %b want 100", {o_ifu_req_ready[0], o_lsu_req_ready[0], o_mem_valid[0]});
        else pass++;
        step();
        ifu_req_valid = 1'b0;
        @(negedge clk);
        chk++;
        if ({o_mem_valid[0], o_mem_ren[0], o_mem_wen[0], o_ifu_rsp_valid[0]} !== 4'b1100)
            $display("FAIL ifu_t1_strobes: got %b want 1100",
                     {o_mem_valid[0], o_mem_ren[0], o_mem_wen[0], o_ifu_rsp_valid[0]});
        else pass++;
        chk++;
        if (o_mem_raddr[0] !== 32'h8000_0000) $display("FAIL ifu_t1_raddr: got %h want 80000000", o_mem_raddr[0]);
        else pass++;
        chk++;
        if (o_mem_wmask[0] !== 8'h00) $display("FAIL ifu_t1_wmask: got %h want 00", o_mem_wmask[0]);
        else pass++;
        step();
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk++;
        if ({o_ifu_rsp_valid[0], o_lsu_rsp_valid[0], o_mem_valid[0]} !== 3'b100)
            $display("FAIL ifu_t2_valid: got %b want 100", {o_ifu_rsp_valid[0], o_lsu_rsp_valid[0], o_mem_valid[0]});
        else pass++;
        chk++;
        if (o_ifu_rdata[0] !== 32'h0000_0413) $display("FAIL ifu_t2_rdata: got %h want 00000413", o_ifu_rdata[0]);
        else pass++;
        step();
        @(negedge clk);
        chk++;
        if ({o_ifu_rsp_valid[0], o_ifu_rdata[0]} !== 33'd0)
            $display("FAIL ifu_t3_idle: got %b/%h want 0/00000000", o_ifu_rsp_valid[0], o_ifu_rdata[0]);
        else pass++;
    endtask

    task automatic test_round_robin();
        logic exp_lsu [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bit got;
        sel = 0;
        do_reset();
        lsu_addr = 32'h8000_0200; lsu_wen = 1'b0; lsu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0010; ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
        mem_rdata = 32'h1111_2222;
        for (int i = 0; i < 5; i++) begin
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (o_ifu_req_ready[0] || o_lsu_req_ready[0]) begin got = 1'b1; break; end
            end
            chk++;
            if (!got) $display("FAIL rr_grant%0d: got timeout want ready", i);
            else if ({o_ifu_req_ready[0], o_lsu_req_ready[0]} !== {!exp_lsu[i], exp_lsu[i]})
                $display("FAIL rr_grant%0d: got %b want %b", i,
                         {o_ifu_req_ready[0], o_lsu_req_ready[0]}, {!exp_lsu[i], exp_lsu[i]});
            else pass++;
            step();
            if (i == 0) ifu_req_valid = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (o_ifu_rsp_valid[0] || o_lsu_rsp_valid[0]) begin got = 1'b1; break; end
            end
            chk++;
            if (!got) $display("FAIL rr_rsp%0d: got timeout want rsp_valid", i);
            else if ({o_ifu_rsp_valid[0], o_lsu_rsp_valid[0]} !== {!exp_lsu[i], exp_lsu[i]} ||
                     (o_ifu_rdata[0] | o_lsu_rdata[0]) !== 32'h1111_2222)
                $display("FAIL rr_rsp%0d: got %b/%h want %b/11112222", i,
                         {o_ifu_rsp_valid[0], o_lsu_rsp_valid[0]}, o_ifu_rdata[0] | o_lsu_rdata[0],
                         {!exp_lsu[i], exp_lsu[i]});
            else pass++;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    endtask

    task automatic test_store();
        sel = 1;
        do_reset();
        lsu_addr = 32'h8000_0100; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
        lsu_wen = 1'b1; lsu_req_valid = 1'b1; lsu_rsp_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk++;
        if (o_lsu_req_ready[1] !== 1'b1) $display("FAIL st_accept: got %b want 1", o_lsu_req_ready[1]);
        else pass++;
        step();
        lsu_req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk++;
            if (o_mem_wen[1] !== (c == 3)) $display("FAIL st_wen_c%0d: got %b want %b", c, o_mem_wen[1], c == 3);
            else pass++;
            chk++;
            if (o_lsu_rsp_valid[1] !== (c == 4))
                $display("FAIL st_rspv_c%0d: got %b want %b", c, o_lsu_rsp_valid[1], c == 4);
            else pass++;
            if (c == 3) begin
                chk++;
                if ({o_mem_valid[1], o_mem_ren[1], o_mem_waddr[1], o_mem_wdata[1], o_mem_wmask[1]} !==
                    {1'b1, 1'b0, 32'h8000_0100, 32'hDEAD_BEEF, 8'h0F})
                    $display("FAIL st_access: got v%b r%b %h %h %h want v1 r0 80000100 deadbeef 0f",
                             o_mem_valid[1], o_mem_ren[1], o_mem_waddr[1], o_mem_wdata[1], o_mem_wmask[1]);
                else pass++;
            end
            if (c == 4) begin
                chk++;
                if (o_lsu_rdata[1] !== 32'd0) $display("FAIL st_rdata: got %h want 00000000", o_lsu_rdata[1]);
                else pass++;
            end
        end
    endtask

    task automatic test_hold();
        sel = 0;
        do_reset();
        ifu_addr = 32'h8000_0004; ifu_req_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk++;
        if (o_ifu_req_ready[0] !== 1'b1) $display("FAIL hold_accept: got %b want 1", o_ifu_req_ready[0]);
        else pass++;
        step();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0300;
        step();
        mem_rdata = 32'h0BAD_BAD0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk++;
            if ({o_ifu_rsp_valid[0], o_ifu_rdata[0], o_lsu_req_ready[0]} !== {1'b1, 32'hCAFE_F00D, 1'b0})
                $display("FAIL hold_c%0d: got v%b %h lr%b want v1 cafef00d lr0", c,
                         o_ifu_rsp_valid[0], o_ifu_rdata[0], o_lsu_req_ready[0]);
            else pass++;
            step();
        end
        ifu_rsp_ready = 1'b1;
        @(negedge clk);
        chk++;
        if ({o_ifu_rsp_valid[0], o_lsu_req_ready[0]} !== 2'b10)
            $display("FAIL hold_release: got %b want 10", {o_ifu_rsp_valid[0], o_lsu_req_ready[0]});
        else pass++;
        step();
        @(negedge clk);
        chk++;
        if ({o_ifu_rsp_valid[0], o_lsu_req_ready[0]} !== 2'b01)
            $display("FAIL hold_after: got %b want 01", {o_ifu_rsp_valid[0], o_lsu_req_ready[0]});
        else pass++;
        lsu_req_valid = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        int lat;
        sel = 1;
        do_reset();
        lsu_addr = 32'h8000_0100; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
        lsu_wen = 1'b1; lsu_req_valid = 1'b1; lsu_rsp_ready = 1'b1;
        @(negedge clk);
        chk++;
        if (o_lsu_req_ready[1] !== 1'b1) $display("FAIL mid_accept: got %b want 1", o_lsu_req_ready[1]);
        else pass++;
        step();
        lsu_req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            chk++;
            if ({o_mem_wen[1], o_mem_valid[1], o_lsu_rsp_valid[1]} !== 3'b000)
                $display("FAIL mid_quiet_c%0d: got %b want 000", c, {o_mem_wen[1], o_mem_valid[1], o_lsu_rsp_valid[1]});
            else pass++;
        end
        step();
        ifu_addr = 32'h8000_0008; ifu_req_valid = 1'b1; ifu_rsp_ready = 1'b1; mem_rdata = 32'h00A0_0093;
        @(negedge clk);
        chk++;
        if (o_ifu_req_ready[1] !== 1'b1) $display("FAIL mid_next_accept: got %b want 1", o_ifu_req_ready[1]);
        else pass++;
        step();
        ifu_req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (o_ifu_rsp_valid[1]) begin lat = k; break; end
        end
        chk++;
        if (lat != 4) $display("FAIL mid_next_latency: got %0d want 4", lat);
        else pass++;
        chk++;
        if (o_ifu_rdata[1] !== 32'h00A0_0093) $display("FAIL mid_next_rdata: got %h want 00a00093", o_ifu_rdata[1]);
        else pass++;
    endtask

    initial begin
        sel = 0;
        rst = 1'b1;
        test_reset();
        test_ifu_read();
        test_round_robin();
        test_store();
        test_hold();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
